// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush, divide sequencing and exception redirect control
module hazard_ctrl #(
  parameter int          NSTAGES     = 5,
  parameter int          REG_W       = 5,
  parameter bit          IGNORE_R0   = 1'b1,
  parameter logic [11:0] EXC_VEC_OFF = 12'h180,
  parameter logic [31:0] EXC_ERET    = 32'h0000_000e
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   ex_rt,
  input  logic [REG_W-1:0]   mem_rt,
  input  logic               ex_rmem,
  input  logic               mem_rmem,
  input  logic               id_j_b_stall,
  input  logic               ex_div_op,
  input  logic               div_ready,
  input  logic               ex_mult_stall,
  input  logic               stallreq_from_if,
  input  logic               stallreq_from_mem,
  input  logic [31:0]        mem_excepttype,
  input  logic [31:0]        mem_cp0_epc,
  input  logic [31:0]        ebase,
  input  logic               bev,
  input  logic               if_ready,
  output logic [NSTAGES-1:0] stall,
  output logic [NSTAGES-1:0] flush,
  output logic               div_start,
  output logic               div_cancel,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_START, DIV_WAIT, DIV_DONE} div_state_t;

  div_state_t          div_state;
  logic                pend;
  logic [31:0]         held_pc;

  logic                exc;
  logic                lwstall;
  logic                divstall;
  logic                back;
  logic                front;
  logic [31:0]         tgt;
  logic [NSTAGES-1:0]  stall_raw;
  logic [NSTAGES-1:0]  flush_raw;

  function automatic logic match(input logic [REG_W-1:0] r,
                                 input logic [REG_W-1:0] rs,
                                 input logic [REG_W-1:0] rt);
    return ((r == rs) || (r == rt)) && !(IGNORE_R0 && (r == '0));
  endfunction

  always_comb begin
    exc      = |mem_excepttype;
    lwstall  = (ex_rmem && match(ex_rt, id_rs, id_rt)) ||
               (mem_rmem && match(mem_rt, id_rs, id_rt));
    divstall = ((div_state == DIV_IDLE) && ex_div_op && !exc) ||
               (div_state == DIV_START) || (div_state == DIV_WAIT);
    back     = divstall || stallreq_from_mem || ex_mult_stall;
    front    = lwstall || id_j_b_stall || stallreq_from_if || back;

    for (int k = 0; k < NSTAGES; k++) begin
      stall_raw[k] = (k < 2) ? front : back;
      flush_raw[k] = exc;
    end
    flush_raw[0] = exc || pend;
    // Bubble EX behind a held ID only when the back end is actually moving.
    flush_raw[2] = exc || ((lwstall || id_j_b_stall) && !back);

    if (mem_excepttype == EXC_ERET) tgt = mem_cp0_epc;
    else if (bev)                   tgt = 32'hBFC0_0380;
    else                            tgt = {ebase[31:12], EXC_VEC_OFF};
  end

  always_comb begin
    if (rst) begin
      stall          = '0;
      flush          = '1;
      div_start      = 1'b0;
      div_cancel     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
    end else begin
      stall          = stall_raw & ~flush_raw;
      flush          = flush_raw;
      div_start      = (div_state == DIV_START) && !exc;
      div_cancel     = (div_state == DIV_WAIT) && exc;
      redirect_valid = exc || pend;
      redirect_pc    = exc ? tgt : (pend ? held_pc : 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_state <= DIV_IDLE;
      pend      <= 1'b0;
      held_pc   <= 32'h0;
    end else begin
      unique case (div_state)
        DIV_IDLE:  if (ex_div_op && !exc) div_state <= DIV_START;
        DIV_START: div_state <= exc ? DIV_IDLE : DIV_WAIT;
        DIV_WAIT:  if (exc) div_state <= DIV_IDLE;
                   else if (div_ready) div_state <= DIV_DONE;
        DIV_DONE:  div_state <= DIV_IDLE;
        default:   div_state <= DIV_IDLE;
      endcase

      // A redirect accepted in the same cycle as a new exception carries the newest target.
      if (exc) begin
        pend <= !if_ready;
        if (!if_ready) held_pc <= tgt;
      end else if (pend && if_ready) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int NS = 5;
  localparam logic [31:0] ERET = 32'h0000_000e;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rt, mem_rt;
  logic          ex_rmem, mem_rmem, id_j_b_stall, ex_div_op, div_ready, ex_mult_stall;
  logic          stallreq_from_if, stallreq_from_mem, bev, if_ready;
  logic [31:0]   mem_excepttype, mem_cp0_epc, ebase;
  logic [NS-1:0] stall, flush;
  logic          div_start, div_cancel, redirect_valid;
  logic [31:0]   redirect_pc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.NSTAGES(NS)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .mem_rt(mem_rt),
    .ex_rmem(ex_rmem), .mem_rmem(mem_rmem), .id_j_b_stall(id_j_b_stall),
    .ex_div_op(ex_div_op), .div_ready(div_ready), .ex_mult_stall(ex_mult_stall),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
    .mem_excepttype(mem_excepttype), .mem_cp0_epc(mem_cp0_epc), .ebase(ebase), .bev(bev),
    .if_ready(if_ready), .stall(stall), .flush(flush), .div_start(div_start),
    .div_cancel(div_cancel), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [4:0]    rs, rt, ert, mrt;
    logic          erm, mrm, jb, ifs, mems, mult;
    logic [NS-1:0] exp_stall, exp_flush;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; ex_rt = 0; mem_rt = 0; ex_rmem = 0; mem_rmem = 0;
    id_j_b_stall = 0; ex_div_op = 0; div_ready = 0; ex_mult_stall = 0;
    stallreq_from_if = 0; stallreq_from_mem = 0; mem_excepttype = 0;
    mem_cp0_epc = 0; ebase = 0; bev = 0; if_ready = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Reference: expected redirect target from the exception cause.
  function automatic logic [31:0] ref_tgt(input logic [31:0] et, input logic [31:0] epc,
                                          input logic b, input logic [31:0] eb);
    if (et == ERET) return epc;
    if (b) return 32'hBFC0_0380;
    return (eb & 32'hFFFF_F000) + 32'h180;
  endfunction

  int m_pend;
  logic [31:0] m_held;
  int starts;

  initial begin
    idle_inputs();
    rst = 1;
    next_cycle(); settle();
    check("reset_stall", stall, 0);
    check("reset_flush", flush, 5'b11111);
    check("reset_div_start", div_start, 0);
    check("reset_redirect_valid", redirect_valid, 0);
    next_cycle();
    rst = 0;

    vecs[0] = '{5, 0, 5, 0, 1, 0, 0, 0, 0, 0, 5'b00011, 5'b00100};
    vecs[1] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b00000};
    vecs[2] = '{0, 7, 0, 7, 0, 1, 0, 0, 0, 0, 5'b00011, 5'b00100};
    vecs[3] = '{5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000};
    vecs[4] = '{1, 2, 3, 4, 0, 0, 1, 0, 0, 0, 5'b00011, 5'b00100};
    vecs[5] = '{1, 2, 3, 4, 0, 0, 0, 1, 0, 0, 5'b00011, 5'b00000};
    vecs[6] = '{1, 2, 3, 4, 0, 0, 0, 0, 1, 0, 5'b11111, 5'b00000};
    vecs[7] = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 1, 5'b11111, 5'b00000};
    vecs[8] = '{5, 0, 5, 0, 1, 0, 0, 0, 1, 0, 5'b11111, 5'b00000};
    vecs[9] = '{0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 5'b00000, 5'b00000};
    for (int i = 0; i < 10; i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rt = vecs[i].ert; mem_rt = vecs[i].mrt;
      ex_rmem = vecs[i].erm; mem_rmem = vecs[i].mrm; id_j_b_stall = vecs[i].jb;
      stallreq_from_if = vecs[i].ifs; stallreq_from_mem = vecs[i].mems;
      ex_mult_stall = vecs[i].mult;
      settle();
      check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      check($sformatf("vec%0d_flush", i), flush, vecs[i].exp_flush);
      next_cycle();
    end
    idle_inputs();

    // Divide: op enters EX, ready after 10 cycles, released in DONE.
    ex_div_op = 1; starts = 0;
    for (int c = 0; c <= 10; c++) begin
      div_ready = (c == 10);
      settle();
      check($sformatf("div_stall_c%0d", c), stall, 5'b11111);
      check($sformatf("div_start_c%0d", c), div_start, (c == 1));
      if (div_start) starts++;
      next_cycle();
    end
    div_ready = 0; ex_div_op = 0;
    settle();
    check("div_done_stall", stall, 0);
    check("div_start_count", starts, 1);
    next_cycle(); next_cycle();

    // Divide cancelled by an exception while waiting.
    ex_div_op = 1; next_cycle(); next_cycle(); next_cycle();
    mem_excepttype = 32'h1;
    settle();
    check("cancel_pulse", div_cancel, 1);
    check("cancel_flush", flush, 5'b11111);
    check("cancel_stall", stall, 0);
    next_cycle();
    mem_excepttype = 0; ex_div_op = 0; starts = 0;
    settle();
    check("cancel_low", div_cancel, 0);
    for (int c = 0; c < 4; c++) begin
      settle();
      if (div_start) starts++;
      next_cycle();
    end
    check("cancel_no_restart", starts, 0);

    // Exception held until fetch accepts it.
    bev = 0; ebase = 32'h8000_1000; if_ready = 0; mem_excepttype = 32'h4;
    settle();
    check("exc_pc", redirect_pc, 32'h8000_1180);
    check("exc_valid", redirect_valid, 1);
    next_cycle();
    mem_excepttype = 0;
    for (int c = 0; c < 2; c++) begin
      settle();
      check($sformatf("pend_pc_c%0d", c), redirect_pc, 32'h8000_1180);
      check($sformatf("pend_valid_c%0d", c), redirect_valid, 1);
      check($sformatf("pend_flush_c%0d", c), flush, 5'b00001);
      next_cycle();
    end
    if_ready = 1;
    settle();
    check("accept_valid", redirect_valid, 1);
    next_cycle();
    settle();
    check("after_accept_valid", redirect_valid, 0);
    check("after_accept_pc", redirect_pc, 0);
    next_cycle();

    // ERET beats BEV; BEV vector otherwise.
    mem_excepttype = ERET; mem_cp0_epc = 32'h8000_0040; bev = 1;
    settle();
    check("eret_pc", redirect_pc, 32'h8000_0040);
    next_cycle();
    mem_excepttype = 32'h8;
    settle();
    check("bev_pc", redirect_pc, 32'hBFC0_0380);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Reset asserted mid-wait with a redirect pending.
    mem_excepttype = 32'h1; if_ready = 0; next_cycle();
    mem_excepttype = 0; ex_div_op = 1; next_cycle(); next_cycle(); next_cycle();
    rst = 1;
    settle();
    check("rst_mid_stall", stall, 0);
    check("rst_mid_flush", flush, 5'b11111);
    check("rst_mid_valid", redirect_valid, 0);
    next_cycle();
    rst = 0; ex_div_op = 0;
    settle();
    check("post_rst_valid", redirect_valid, 0);
    check("post_rst_stall", stall, 0);
    check("post_rst_div_start", div_start, 0);
    next_cycle();
    idle_inputs();

    // Random hazards, stalls and exceptions with the divider idle.
    m_pend = 0; m_held = 0;
    for (int c = 0; c < 300; c++) begin
      logic [NS-1:0] es, ef;
      logic hz, fr, bk, ex;
      logic [31:0] t;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3)); mem_rt = 5'($urandom_range(0, 3));
      ex_rmem = 1'($urandom); mem_rmem = 1'($urandom);
      id_j_b_stall = ($urandom_range(0, 5) == 0);
      stallreq_from_if = ($urandom_range(0, 5) == 0);
      stallreq_from_mem = ($urandom_range(0, 5) == 0);
      ex_mult_stall = ($urandom_range(0, 5) == 0);
      div_ready = 1'($urandom);
      case ($urandom_range(0, 7))
        0: mem_excepttype = ERET;
        1: mem_excepttype = 32'h20;
        default: mem_excepttype = 0;
      endcase
      mem_cp0_epc = $urandom; ebase = $urandom; bev = 1'($urandom); if_ready = 1'($urandom);

      hz = (ex_rmem && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt)) ||
           (mem_rmem && mem_rt != 0 && (mem_rt == id_rs || mem_rt == id_rt));
      ex = (mem_excepttype != 0);
      bk = stallreq_from_mem || ex_mult_stall;
      fr = hz || id_j_b_stall || stallreq_from_if || bk;
      for (int k = 0; k < NS; k++) begin
        ef[k] = ex || (k == 0 && m_pend != 0) || (k == 2 && (hz || id_j_b_stall) && !bk);
        es[k] = ((k < 2) ? fr : bk) && !ef[k];
      end
      t = ref_tgt(mem_excepttype, mem_cp0_epc, bev, ebase);
      settle();
      check($sformatf("rnd%0d_stall", c), stall, es);
      check($sformatf("rnd%0d_flush", c), flush, ef);
      check($sformatf("rnd%0d_valid", c), redirect_valid, ex || m_pend != 0);
      check($sformatf("rnd%0d_pc", c), redirect_pc, ex ? t : (m_pend != 0 ? m_held : 0));
      if (ex) begin
        m_pend = if_ready ? 0 : 1;
        if (!if_ready) m_held = t;
      end else if (if_ready) begin
        m_pend = 0;
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard and redirect controller for the MIPS core, generating per-stage stall and flush vectors for an NSTAGES-deep in-order pipeline. Detects load-use hazards, ignoring register $0. Sequences multi-cycle divides through a pulse-start FSM that can be cancelled. Holds exception/ERET redirect PCs until fetch accepts them. Sits beside the datapath and drives every pipeline register's stall/flush.

Parameters:
NSTAGES, 5, pipeline depth; index 0=IF, 1=ID, 2=EX, 3=MEM, 4..NSTAGES-1=WB and later; must be >=5
REG_W, 5, register specifier width
IGNORE_R0, 1, 1: a specifier of 0 never causes a load-use hazard
EXC_VEC_OFF, 12'h180, general exception offset from EBASE

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs, id_rt  in  REG_W  ID-stage source specifiers
ex_rt, mem_rt  in  REG_W  load destinations in EX/MEM
ex_rmem, mem_rmem  in  1  EX/MEM instruction is a load
id_j_b_stall  in  1  branch operand not ready
ex_div_op  in  1  EX holds DIV/DIVU
div_ready  in  1  divider result valid
ex_mult_stall  in  1  multiplier busy
stallreq_from_if, stallreq_from_mem  in  1  memory-interface stalls
mem_excepttype  in  32  nonzero = exception in MEM
mem_cp0_epc, ebase  in  32  CP0 EPC / EBase
bev  in  1  CP0 Status.BEV
if_ready  in  1  fetch accepts redirect this cycle
stall  out  NSTAGES  per-stage hold
flush  out  NSTAGES  per-stage bubble insert
div_start  out  1  one-cycle divider launch pulse
div_cancel  out  1  one-cycle divider abort pulse
redirect_valid  out  1  PC redirect request
redirect_pc  out  32  redirect target

Behaviour:
- Reset: div FSM = IDLE, pend = 0, held_pc = 0. While rst is high: stall = 0, flush = all ones, div_start = 0, div_cancel = 0, redirect_valid = 0.
- match(r) = (r==id_rs | r==id_rt) & !(IGNORE_R0 & r==0).
- lwstall = ex_rmem&match(ex_rt) | mem_rmem&match(mem_rt).
- exc = (mem_excepttype != 0).
- Div FSM states:
  - IDLE: ex_div_op & !exc -> START.
  - START: div_start=1 for exactly one cycle -> WAIT. If exc -> IDLE.
  - WAIT: div_ready -> DONE. If exc -> IDLE with div_cancel=1 for one cycle.
  - DONE: stall released for one cycle so EX advances -> IDLE.
  - exc takes priority over div_ready in the same cycle.
- divstall = (IDLE & ex_div_op & !exc) | START | WAIT.
- back = divstall | stallreq_from_mem | ex_mult_stall.
- stall[0], stall[1] = lwstall | id_j_b_stall | stallreq_from_if | back.
- stall[k>=2] = back.
- flush[k] = exc | pend for k=0; exc for k>=1.
- flush[2] also = (lwstall|id_j_b_stall) & !stall[3].
- flush has priority over stall for the same stage.
- Redirect target tgt:
  - mem_excepttype == EXC_ERET -> mem_cp0_epc.
  - bev -> 32'hBFC00380.
  - otherwise -> {ebase[31:12], EXC_VEC_OFF}.
- redirect_valid = exc | pend.
- redirect_pc = exc ? tgt : held_pc (combinational on exc, no added latency).
- Pending redirect register:
  - exc & !if_ready: pend<=1, held_pc<=tgt.
  - pend & if_ready & !exc: pend<=0.
  - A new exc while pend is set overwrites held_pc (newest wins).
- redirect_pc = 0 when !redirect_valid (no latch).

Test Plan:
- ex_rmem=1, ex_rt=5, id_rs=5 -> stall[1:0]=11, flush[2]=1, stall[4:2]=0. Repeat with ex_rt=0 -> no stall (IGNORE_R0=1).
- ex_div_op held, div_ready after 10 cycles -> div_start high exactly 1 cycle (cycle after EX entry); stall[4:0]=all ones for 11 cycles; DONE cycle stall=0.
- mem_excepttype=nonzero during WAIT -> div_cancel 1-cycle pulse, FSM IDLE, flush=all ones, div_start never re-pulses for the flushed op.
- Exception with bev=0, ebase=32'h80001000, if_ready=0 for 3 cycles -> redirect_pc=32'h80001180 held, redirect_valid=1 until the if_ready cycle, then 0.
- ERET (EXC_ERET) with epc=32'h8000_0040, bev=1 -> redirect_pc=32'h80000040 (not BFC00380).
- Assert rst mid-WAIT -> next cycle FSM IDLE, pend=0, stall=0, flush=all ones while rst is high.
